// File: rtl/icache_if.sv
// icache_if: fetch-side and memory-side signals of the instruction cache
//   fetch:  addr, instr, imem_stall, flush
//   memory: mem_req, mem_addr, mem_ack, mem_rdata
//   stats:  hit_count, miss_count
//   slave modport is the cache itself; master is the fetch stage plus memory.
interface icache_if;
  logic [31:0] addr;
  logic [31:0] instr;
  logic        imem_stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  modport slave (
    input  addr, flush, mem_ack, mem_rdata,
    output instr, imem_stall, mem_req, mem_addr, hit_count, miss_count
  );
  modport master (
    output addr, flush, mem_ack, mem_rdata,
    input  instr, imem_stall, mem_req, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/icache.sv
// icache: direct-mapped read-only instruction cache, 4-word lines, zero-latency hit, 4-beat line fill
//   clk, rst : clock, synchronous active-high reset
//   bus      : icache_if.slave (addr/instr/imem_stall/flush, mem_req/mem_addr/mem_ack/mem_rdata, hit_count/miss_count)
//   Define ICACHE_STATS_EN to build the hit/miss counters; otherwise they read as 0.
module icache #(
  parameter int LINES = 16
) (
  input logic     clk,
  input logic     rst,
  icache_if.slave bus
);
  localparam int IW = $clog2(LINES);
  localparam int TW = 28 - IW;
  typedef enum logic {IDLE, FILL} state_t;
  state_t           state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TW-1:0]    tag_q [LINES];
  logic [31:0]      data_q [LINES][4];
  logic [27:0]      base_q, base_d;
  logic [1:0]       beat_q, beat_d;
  logic             flushed_q, flushed_d;
  logic [IW-1:0]    idx, fill_idx;
  logic             hit, ack, last;
  assign idx      = bus.addr[4 +: IW];
  assign fill_idx = base_q[IW-1:0];
  assign hit      = (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == bus.addr[31 -: TW]);
  assign ack      = (state_q == FILL) && bus.mem_ack;
  assign last     = ack && (beat_q == 2'd3);
  assign bus.instr      = data_q[idx][bus.addr[3:2]];
  assign bus.imem_stall = ~hit;
  assign bus.mem_req    = state_q == FILL;
  assign bus.mem_addr   = bus.mem_req ? {base_q, beat_q, 2'b00} : 32'd0;
  // flushed_q remembers a flush seen during the current fill so the completed line stays invalid
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    beat_d    = ack ? beat_q + 2'd1 : beat_q;
    flushed_d = flushed_q | bus.flush;
    valid_d   = valid_q;
    if (state_q == IDLE && !hit) begin
      state_d   = FILL;
      base_d    = bus.addr[31:4];
      beat_d    = 2'd0;
      flushed_d = 1'b0;
    end
    if (last) begin
      state_d           = IDLE;
      valid_d[fill_idx] = valid_q[fill_idx] | ~flushed_q;
    end
    if (bus.flush) valid_d = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      base_q    <= '0;
      beat_q    <= '0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      base_q    <= base_d;
      beat_q    <= beat_d;
      flushed_q <= flushed_d;
    end
  end
  always_ff @(posedge clk) begin
    if (ack && !rst) data_q[fill_idx][beat_q] <= bus.mem_rdata;
    if (last && !rst) tag_q[fill_idx] <= base_q[27 -: TW];
  end
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit ? hit_count_q + 32'd1 : hit_count_q;
      miss_count_q <= (state_q == IDLE && !hit) ? miss_count_q + 32'd1 : miss_count_q;
    end
  end
  assign bus.hit_count  = hit_count_q;
  assign bus.miss_count = miss_count_q;
`else
  assign bus.hit_count  = 32'd0;
  assign bus.miss_count = 32'd0;
`endif
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped lines; power of two, >= 2.
REQ-002 Each line holds 4 words (16 bytes), fixed. Index = addr[3+log2(LINES):4], tag = addr[31:4+log2(LINES)], word select = addr[3:2]; addr[1:0] ignored.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 addr  input  32  fetch address (PC) from fetch stage.
REQ-006 instr  output  32  instruction word for addr; valid only when imem_stall=0.
REQ-007 imem_stall  output  1  high while addr misses or a fill is in progress.
REQ-008 flush  input  1  invalidate all lines (fence.i).
REQ-009 mem_req  output  1  memory read request, held for the whole burst.
REQ-010 mem_addr  output  32  word address of the current beat.
REQ-011 mem_ack  input  1  beat accepted; mem_rdata valid this cycle.
REQ-012 mem_rdata  input  32  returned memory word.
REQ-013 hit_count  output  32  hit counter (see Configuration).
REQ-014 miss_count  output  32  miss counter (see Configuration).

Function
REQ-015 Lookup SHALL be combinational: hit = valid[index] & (tag_array[index] == tag) while state is IDLE.
REQ-016 On a hit, instr SHALL equal the selected word with imem_stall=0 in the same cycle (zero-cycle latency).
REQ-017 imem_stall SHALL equal (state != IDLE) | ~hit.
REQ-018 FSM states: IDLE, FILL. IDLE->FILL on a miss, capturing the line base (addr[31:4]) and clearing the beat counter; FILL->IDLE on the 4th mem_ack.
REQ-019 In FILL, mem_req=1 and mem_addr={line_base, beat[1:0], 2'b00}; beats issue in order 0,1,2,3.
REQ-020 On each mem_ack in FILL, mem_rdata SHALL be written to word[beat] of the target line and beat SHALL increment; no-ack cycles hold mem_addr and beat unchanged.
REQ-021 On the 4th ack, tag SHALL be written and valid set, unless a flush occurred during this fill; the next IDLE cycle with the same addr SHALL hit.
REQ-022 mem_ack while mem_req=0 SHALL be ignored.
REQ-023 addr changes during FILL SHALL NOT alter the fill in progress; lookup resumes with the current addr in IDLE.
REQ-024 flush SHALL clear all valid bits at the next edge; flush in IDLE with a concurrent miss SHALL still start the fill; flush in FILL SHALL let the burst complete but leave the line invalid.
REQ-025 Miss to a valid line with a different tag SHALL overwrite it (no write-back; read-only cache).

Reset
REQ-026 rst SHALL clear all valid bits, state=IDLE, beat=0, mem_req=0, mem_addr=0, hit_count=0, miss_count=0; tag/data arrays need no reset.
REQ-027 rst mid-FILL SHALL abort the burst: mem_req=0 the following cycle, target line invalid.
REQ-028 After reset, imem_stall=1 for any addr until filled.

Configuration
REQ-029 Macro ICACHE_STATS_EN defined: hit_count increments each IDLE cycle with hit=1; miss_count increments on each IDLE->FILL transition; both wrap modulo 2^32.
REQ-030 ICACHE_STATS_EN undefined: counters not built; hit_count and miss_count tied to 0; all other behaviour identical.

Verification
REQ-031 Reset, addr=0x00000100, memory acks every cycle with words 0xA0..0xA3 -> imem_stall=1 for 5 cycles, mem_addr 0x100,0x104,0x108,0x10C, then instr=0xA0, imem_stall=0.
REQ-032 After REQ-031 fill, addr=0x10C -> instr=0xA3, imem_stall=0, no mem_req.
REQ-033 LINES=16, fill 0x100 then access 0x200 (same index, new tag) -> refill; return to 0x100 -> misses again.
REQ-034 mem_ack withheld 3 cycles per beat -> mem_addr stable during wait, fill completes after 16 cycles, correct data.
REQ-035 flush asserted during beat 2 -> burst completes, next lookup of that addr misses; flush in IDLE -> all prior hits miss.
REQ-036 rst asserted during beat 1 -> mem_req=0 next cycle, state IDLE, same addr misses; with ICACHE_STATS_EN, REQ-031+032 sequence gives miss_count=1, hit_count>=2.
